caliptra_fpga_apb_sequencer: RTL and testbench
==============================================

CALIPTRA_FPGA_APB_SEQUENCER -- requirements
Module: caliptra_fpga_apb_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max ACCESS-phase cycles with PREADY low before abort; legal range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 2: command FIFO entries; power of two, at least 2.
REQ-003 aclk_gated  input  1  clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO can accept.
REQ-007 cmd_write / cmd_addr / cmd_wdata / cmd_pprot / cmd_pauser  input  1/32/32/3/32  command fields.
REQ-008 resp_valid  output  1  response held.
REQ-009 resp_ready  input  1  response consumed.
REQ-010 resp_rdata / resp_slverr / resp_timeout  output  32/1/1  response fields.
REQ-011 flush  input  1  discard queued, unissued commands.
REQ-012 busy  output  1  state not IDLE, or FIFO not empty.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  queued entries.
REQ-014 PSEL / PENABLE / PWRITE / PADDR / PWDATA / PPROT / PAUSER  output  1/1/1/32/32/3/32  APB requester signals.
REQ-015 PRDATA / PREADY / PSLVERR  input  32/1/1  APB completer signals.

Function
REQ-016 cmd_ready SHALL equal (fifo_level < FIFO_DEPTH) combinationally; a push occurs on cmd_valid && cmd_ready.
REQ-017 A pop in the same cycle as a full FIFO SHALL NOT raise cmd_ready that cycle (no full-bypass).
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP.
REQ-019 IDLE->SETUP when FIFO is non-empty; the head is popped and latched onto PADDR/PWDATA/PWRITE/PPROT/PAUSER on that edge.
REQ-020 A command pushed into an empty FIFO in IDLE at edge N SHALL produce PSEL=1 from edge N+1 (SETUP) and PENABLE=1 from edge N+2 (ACCESS).
REQ-021 SETUP SHALL last exactly one cycle: PSEL=1, PENABLE=0.
REQ-022 ACCESS: PSEL=1, PENABLE=1; APB outputs SHALL remain stable until PREADY=1 is sampled.
REQ-023 ACCESS with PREADY=1 SHALL capture PRDATA (reads; 0 for writes) and PSLVERR, set resp_timeout=0, and go to RESP; PSEL and PENABLE SHALL be 0 in RESP.
REQ-024 In ACCESS a 16-bit wait counter SHALL count cycles with PREADY=0; when it reaches TIMEOUT_CYCLES the FSM SHALL go to RESP with resp_rdata=0, resp_slverr=1, resp_timeout=1.
REQ-025 PREADY=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally (no timeout).
REQ-026 In RESP, resp_valid=1; on resp_ready the FSM goes to IDLE; no new SETUP while a response is unconsumed.
REQ-027 Response fields SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-028 flush SHALL empty the FIFO on the next edge; the in-flight transaction SHALL complete normally.
REQ-029 flush SHALL take priority over a push in the same cycle; that command is dropped.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 fifo_level SHALL update by push minus pop each edge.
REQ-032 When the clock is stopped, all state SHALL hold; no wall-clock timeouts.

Reset
REQ-033 rstn low SHALL immediately force IDLE, PSEL=0, PENABLE=0, resp_valid=0, FIFO empty, fifo_level=0, and the wait counter to 0.
REQ-034 Reset SHALL also force PADDR, PWDATA, PWRITE, PPROT, PAUSER, resp_rdata, resp_slverr and resp_timeout to 0; cmd_ready=1 and busy=0 after reset.
REQ-035 Reset asserted mid-transaction SHALL drop PSEL/PENABLE asynchronously; no response is issued for that transaction.

Verification
REQ-036 Read 0x3002_0000, PREADY high at first ACCESS, PRDATA=0xA5A5_0001 -> PSEL at N+1, PENABLE at N+2, resp_valid at N+3 with rdata=0xA5A5_0001, slverr=0.
REQ-037 Write with 3 PREADY wait cycles and PSLVERR=1 -> ACCESS held 4 cycles with stable APB outputs; resp_slverr=1, resp_rdata=0.
REQ-038 TIMEOUT_CYCLES=4, PREADY stuck low -> response after 4 wait cycles: timeout=1, slverr=1, rdata=0; PSEL drops.
REQ-039 Push 3 commands back-to-back with resp_ready low -> 2 queued plus 1 in flight; cmd_ready=0 at fifo_level=2; issue order preserved.
REQ-040 Two queued commands, flush in ACCESS -> current response delivered, fifo_level=0, no further PSEL.
REQ-041 rstn pulsed low during ACCESS -> PSEL/PENABLE 0 immediately, busy=0, no resp_valid after release.

Source files
------------

// File: rtl/caliptra_fpga_apb_sequencer.sv
// caliptra_fpga_apb_sequencer: queues APB commands and issues them one at a time on an APB requester port.
// Latency: a command pushed into an empty idle queue at edge N gives PSEL at N+1 and PENABLE at N+2.
// Backpressure: cmd_ready drops while the queue is full; no new transfer starts until the held response is consumed.
//
// Ports:
//   aclk_gated, rstn                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready + cmd_* fields     command push interface (write, addr, wdata, pprot, pauser)
//   resp_valid/resp_ready + resp_* fields  response hold interface (rdata, slverr, timeout)
//   flush                                  discard queued, not yet issued commands
//   busy, fifo_level                       status
//   PSEL..PAUSER / PRDATA, PREADY, PSLVERR APB requester outputs / completer inputs
module caliptra_fpga_apb_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                          aclk_gated,
   input  logic                          rstn,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [31:0]                   cmd_addr,
   input  logic [31:0]                   cmd_wdata,
   input  logic [2:0]                    cmd_pprot,
   input  logic [31:0]                   cmd_pauser,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [31:0]                   resp_rdata,
   output logic                          resp_slverr,
   output logic                          resp_timeout,
   input  logic                          flush,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [31:0]                   PADDR,
   output logic [31:0]                   PWDATA,
   output logic [2:0]                    PPROT,
   output logic [31:0]                   PAUSER,
   input  logic [31:0]                   PRDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = 1 + 32 + 32 + 3 + 32;

   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
   localparam logic [15:0]      TMO_L   = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [15:0]          wait_q, wait_d;
   logic                 pwrite_q, pwrite_d;
   logic [31:0]          paddr_q, paddr_d;
   logic [31:0]          pwdata_q, pwdata_d;
   logic [2:0]           pprot_q, pprot_d;
   logic [31:0]          pauser_q, pauser_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 slverr_q, slverr_d;
   logic                 timeout_q, timeout_d;

   logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]   push_entry;
   logic [ENTRY_W-1:0]   head_entry;
   logic                 push;
   logic                 pop;

   // Ready is derived from the registered level only, so a pop while full
   // cannot open a slot in the same cycle.
   assign cmd_ready  = (level_q < DEPTH_L);

   // Flush wins over both a push and an issue in the same cycle.
   assign push       = cmd_valid && cmd_ready && !flush;
   assign pop        = (state_q == IDLE) && (level_q != '0) && !flush;

   assign push_entry = {cmd_write, cmd_addr, cmd_wdata, cmd_pprot, cmd_pauser};
   assign head_entry = mem_q[rd_ptr_q];

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge aclk_gated) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      wait_d    = wait_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pprot_d   = pprot_q;
      pauser_d  = pauser_q;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
      timeout_d = timeout_q;

      // Queue bookkeeping; pointers wrap naturally since the depth is a power of two.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         level_d = level_q + LVL_W'(push) - LVL_W'(pop);
      end

      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = SETUP;
               {pwrite_d, paddr_d, pwdata_d, pprot_d, pauser_d} = head_entry;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            wait_d  = '0;
         end
         ACCESS: begin
            // A completer answering on the cycle the count hits the limit still
            // completes normally; only a low PREADY at the limit aborts.
            if (PREADY) begin
               state_d   = RESP;
               rdata_d   = pwrite_q ? 32'h0 : PRDATA;
               slverr_d  = PSLVERR;
               timeout_d = 1'b0;
               wait_d    = '0;
            end else if (wait_q == TMO_L) begin
               state_d   = RESP;
               rdata_d   = 32'h0;
               slverr_d  = 1'b1;
               timeout_d = 1'b1;
               wait_d    = '0;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk_gated or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         wait_q    <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pprot_q   <= '0;
         pauser_q  <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         wait_q    <= wait_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pprot_q   <= pprot_d;
         pauser_q  <= pauser_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
         timeout_q <= timeout_d;
      end
   end

   // APB strobes decode straight from the state register so reset drops them at once.
   assign PSEL         = (state_q == SETUP) || (state_q == ACCESS);
   assign PENABLE      = (state_q == ACCESS);
   assign PWRITE       = pwrite_q;
   assign PADDR        = paddr_q;
   assign PWDATA       = pwdata_q;
   assign PPROT        = pprot_q;
   assign PAUSER       = pauser_q;

   assign resp_valid   = (state_q == RESP);
   assign resp_rdata   = rdata_q;
   assign resp_slverr  = slverr_q;
   assign resp_timeout = timeout_q;

   assign busy         = (state_q != IDLE) || (level_q != '0);
   assign fifo_level   = level_q;

endmodule

// File: tb/tb_caliptra_fpga_apb_sequencer.sv
// tb_caliptra_fpga_apb_sequencer: directed bench for the APB sequencer, TIMEOUT_CYCLES=4, FIFO_DEPTH=2.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Single transactions come from a vector table; queueing, flush and reset use hand-written sequences.
module tb_caliptra_fpga_apb_sequencer;

   logic        aclk_gated = 1'b0;
   logic        rstn       = 1'b0;
   logic        cmd_valid  = 1'b0;
   logic        cmd_ready;
   logic        cmd_write  = 1'b0;
   logic [31:0] cmd_addr   = '0;
   logic [31:0] cmd_wdata  = '0;
   logic [2:0]  cmd_pprot  = '0;
   logic [31:0] cmd_pauser = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_slverr;
   logic        resp_timeout;
   logic        flush      = 1'b0;
   logic        busy;
   logic [1:0]  fifo_level;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [2:0]  PPROT;
   logic [31:0] PAUSER;
   logic [31:0] PRDATA     = '0;
   logic        PREADY     = 1'b0;
   logic        PSLVERR    = 1'b0;

   int checks   = 0;
   int failures = 0;

   caliptra_fpga_apb_sequencer #(
      .TIMEOUT_CYCLES (4),
      .FIFO_DEPTH     (2)
   ) dut (
      .aclk_gated   (aclk_gated),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .cmd_pprot    (cmd_pprot),
      .cmd_pauser   (cmd_pauser),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_slverr  (resp_slverr),
      .resp_timeout (resp_timeout),
      .flush        (flush),
      .busy         (busy),
      .fifo_level   (fifo_level),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PADDR        (PADDR),
      .PWDATA       (PWDATA),
      .PPROT        (PPROT),
      .PAUSER       (PAUSER),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR)
   );

   always #5 aclk_gated = ~aclk_gated;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  pprot;
      logic [31:0] pauser;
      int          waits;       // PREADY low cycles before it rises (99 = never)
      logic [31:0] prdata;
      logic        pslverr;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      logic        exp_timeout;
      int          exp_cycles;  // ACCESS cycles with PENABLE high
   } vec_t;

   vec_t vecs [5];

   task automatic step();
      @(posedge aclk_gated);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic push_cmd(input logic wr, input logic [31:0] addr);
      cmd_valid  = 1'b1;
      cmd_write  = wr;
      cmd_addr   = addr;
      cmd_wdata  = ~addr;
      cmd_pprot  = 3'b001;
      cmd_pauser = 32'h0000_00AA;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  k;
      bit  done;
      logic [31:0] held;
      cmd_valid  = 1'b1;
      cmd_write  = v.wr;
      cmd_addr   = v.addr;
      cmd_wdata  = v.wdata;
      cmd_pprot  = v.pprot;
      cmd_pauser = v.pauser;
      step();                                   // edge N: push
      cmd_valid = 1'b0;
      check($sformatf("v%0d_level_after_push", idx), 32'(fifo_level), 32'd1);
      check($sformatf("v%0d_psel_at_N", idx), 32'(PSEL), 32'd0);
      step();                                   // edge N+1: SETUP
      check($sformatf("v%0d_setup_strobes", idx), {30'd0, PSEL, PENABLE}, 32'b10);
      check($sformatf("v%0d_paddr", idx), PADDR, v.addr);
      check($sformatf("v%0d_pwdata", idx), PWDATA, v.wdata);
      check($sformatf("v%0d_ctl", idx), {25'd0, PWRITE, PPROT, 3'd0}, {25'd0, v.wr, v.pprot, 3'd0});
      check($sformatf("v%0d_pauser", idx), PAUSER, v.pauser);
      k       = 1;
      PREADY  = (k > v.waits);
      PRDATA  = v.prdata;
      PSLVERR = v.pslverr;
      step();                                   // edge N+2: ACCESS
      done = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
         check($sformatf("v%0d_access_strobes_c%0d", idx, k), {30'd0, PSEL, PENABLE}, 32'b11);
         check($sformatf("v%0d_access_paddr_c%0d", idx, k), PADDR, v.addr);
         check($sformatf("v%0d_access_pwdata_c%0d", idx, k), PWDATA, v.wdata);
         step();
         if (resp_valid) begin
            done = 1'b1;
         end else begin
            k++;
            PREADY = (k > v.waits);
         end
      end
      PREADY = 1'b0;
      if (!done) check($sformatf("v%0d_resp_within_bound", idx), 32'd0, 32'd1);
      check($sformatf("v%0d_access_cycles", idx), 32'(k), 32'(v.exp_cycles));
      check($sformatf("v%0d_resp_strobes", idx), {30'd0, PSEL, PENABLE}, 32'b00);
      check($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
      check($sformatf("v%0d_err_flags", idx), {30'd0, resp_slverr, resp_timeout},
            {30'd0, v.exp_slverr, v.exp_timeout});
      held = resp_rdata;
      PRDATA = 32'hFFFF_0000;
      step();                                   // response held with resp_ready low
      check($sformatf("v%0d_resp_held_valid", idx), 32'(resp_valid), 32'd1);
      check($sformatf("v%0d_resp_held_rdata", idx), resp_rdata, v.exp_rdata);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check($sformatf("v%0d_resp_consumed", idx), {30'd0, resp_valid, busy}, 32'b00);
   endtask

   initial begin
      logic [31:0] issued [4];
      int n_issued;
      int n_resp;
      int n_psel;

      //          wr    addr          wdata         pprot   pauser        waits prdata        slverr exp_rdata     slv   tmo   cyc
      vecs[0] = '{1'b0, 32'h3002_0000, 32'h0,        3'b000, 32'h0,        0,    32'hA5A5_0001, 1'b0,  32'hA5A5_0001, 1'b0, 1'b0, 1};
      vecs[1] = '{1'b1, 32'h3002_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_1234, 3,   32'h5555_AAAA, 1'b1,  32'h0,        1'b1, 1'b0, 4};
      vecs[2] = '{1'b0, 32'h3002_0020, 32'h0,        3'b111, 32'hFFFF_0001, 99,   32'h1111_1111, 1'b0,  32'h0,        1'b1, 1'b1, 5};
      vecs[3] = '{1'b0, 32'h3002_0030, 32'h0,        3'b100, 32'h8000_0000, 4,    32'hCAFE_F00D, 1'b0,  32'hCAFE_F00D, 1'b0, 1'b0, 5};
      vecs[4] = '{1'b0, 32'h3002_0040, 32'h0,        3'b011, 32'h0000_0055, 1,    32'h0BAD_F00D, 1'b1,  32'h0BAD_F00D, 1'b1, 1'b0, 2};

      // Reset state
      step();
      step();
      check("rst_strobes", {29'd0, PSEL, PENABLE, resp_valid}, 32'b000);
      check("rst_status", {28'd0, cmd_ready, busy, fifo_level}, {28'd0, 1'b1, 1'b0, 2'd0});
      check("rst_apb_fields", PADDR | PWDATA | PAUSER | {28'd0, PWRITE, PPROT}, 32'h0);
      check("rst_resp_fields", resp_rdata | {30'd0, resp_slverr, resp_timeout}, 32'h0);
      #3 rstn = 1'b1;
      step();

      for (int i = 0; i < 5; i++) begin
         run_vec(i, vecs[i]);
      end

      // Three back-to-back pushes with resp_ready low: one in flight, two queued.
      push_cmd(1'b0, 32'h4000_0000);
      step();                                   // push A
      push_cmd(1'b1, 32'h4000_0004);
      step();                                   // SETUP A, push B
      check("q_first_setup", PADDR, 32'h4000_0000);
      push_cmd(1'b0, 32'h4000_0008);
      step();                                   // ACCESS A, push C
      check("q_full_level", 32'(fifo_level), 32'd2);
      check("q_full_ready", 32'(cmd_ready), 32'd0);
      push_cmd(1'b0, 32'h4000_000C);            // D must be refused
      step();
      check("q_refused_level", 32'(fifo_level), 32'd2);
      cmd_valid  = 1'b0;
      PREADY     = 1'b1;
      PRDATA     = 32'h1234_5678;
      step();                                   // RESP A, held
      check("q_resp_held_valid", 32'(resp_valid), 32'd1);
      step();
      check("q_no_setup_while_resp", {30'd0, PSEL, resp_valid}, 32'b01);
      resp_ready = 1'b1;
      n_issued = 0;
      n_resp   = 0;
      for (int t = 0; t < 30; t++) begin
         if (resp_valid) n_resp++;
         step();
         if (PSEL && !PENABLE) begin
            if (n_issued < 4) issued[n_issued] = PADDR;
            n_issued++;
         end
      end
      check("q_issue_count", 32'(n_issued), 32'd2);
      check("q_issue_order_b", issued[0], 32'h4000_0004);
      check("q_issue_order_c", issued[1], 32'h4000_0008);
      check("q_resp_count", 32'(n_resp), 32'd3);
      check("q_idle_after", 32'(busy), 32'd0);
      resp_ready = 1'b0;
      PREADY     = 1'b0;

      // Flush with two queued and one in ACCESS; flush also beats a concurrent push.
      push_cmd(1'b0, 32'h5000_0000);
      step();
      push_cmd(1'b0, 32'h5000_0004);
      step();
      push_cmd(1'b0, 32'h5000_0008);
      step();                                   // ACCESS, level 2
      check("f_pre_level", 32'(fifo_level), 32'd2);
      cmd_valid = 1'b0;
      flush     = 1'b1;
      step();
      check("f_level_zero", 32'(fifo_level), 32'd0);
      check("f_inflight_kept", {30'd0, PSEL, PENABLE}, 32'b11);
      push_cmd(1'b0, 32'h5000_000C);            // cmd_ready is 1 now, flush must drop it
      step();
      cmd_valid = 1'b0;
      flush     = 1'b0;
      check("f_push_dropped", 32'(fifo_level), 32'd0);
      PREADY     = 1'b1;
      PRDATA     = 32'h0F0F_0F0F;
      resp_ready = 1'b1;
      n_resp = 0;
      n_psel = 0;
      for (int t = 0; t < 20; t++) begin
         step();
         if (resp_valid) begin
            n_resp++;
            check("f_resp_rdata", resp_rdata, 32'h0F0F_0F0F);
         end
         if (PSEL && !PENABLE) n_psel++;
      end
      check("f_resp_count", 32'(n_resp), 32'd1);
      check("f_no_new_setup", 32'(n_psel), 32'd0);
      check("f_idle_after", 32'(busy), 32'd0);
      resp_ready = 1'b0;
      PREADY     = 1'b0;

      // Reset pulsed during ACCESS with another command queued.
      push_cmd(1'b0, 32'h6000_0000);
      step();
      push_cmd(1'b0, 32'h6000_0004);
      step();
      cmd_valid = 1'b0;
      step();                                   // ACCESS, one queued
      check("r_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
      rstn = 1'b0;
      #2;
      check("r_async_strobes", {29'd0, PSEL, PENABLE, resp_valid}, 32'b000);
      check("r_async_status", {28'd0, cmd_ready, busy, fifo_level}, {28'd0, 1'b1, 1'b0, 2'd0});
      step();
      rstn       = 1'b1;
      PREADY     = 1'b1;
      resp_ready = 1'b1;
      n_resp = 0;
      n_psel = 0;
      for (int t = 0; t < 10; t++) begin
         step();
         if (resp_valid) n_resp++;
         if (PSEL) n_psel++;
      end
      check("r_no_resp_after", 32'(n_resp), 32'd0);
      check("r_no_psel_after", 32'(n_psel), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
